// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S frame scheduler.
package i2s_pkg;

    localparam int I2S_PDATA_WIDTH = 32;
    localparam int STATS_WIDTH     = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        DELAY,
        CAPTURE
    } frame_state_t;

    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_edge_det.sv
// Registers a level once and reports single-cycle rise/fall pulses against the live input.
module i2s_edge_det (
    input  logic clk_in,
    input  logic rst_in,
    input  logic level_in,
    output logic rise_out,
    output logic fall_out
);

    logic r_level_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= level_in;
        end
    end

    assign rise_out = ~r_level_q & level_in;
    assign fall_out = r_level_q & ~level_in;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Once-per-frame capture of the received L/R pair and load of the next transmit pair.
// Defining I2S_FRAME_CTRL_STATS_EN adds saturating frame/overrun/underrun counter ports.
module i2s_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int PDATA_WIDTH        = I2S_PDATA_WIDTH,
    parameter int CAPTURE_DELAY_SCLK = 2,
    parameter int UNDERRUN_HOLD      = 0
) (
    input  logic                   mclk_in,
    input  logic                   rst_in,
    input  logic                   enable_in,
    input  logic                   lrck_in,
    input  logic                   sclk_in,
    input  logic [PDATA_WIDTH-1:0] pldata_rx_in,
    input  logic [PDATA_WIDTH-1:0] prdata_rx_in,
    output logic [PDATA_WIDTH-1:0] pldata_tx_out,
    output logic [PDATA_WIDTH-1:0] prdata_tx_out,
    output logic                   rx_valid_out,
    input  logic                   rx_ready_in,
    output logic [PDATA_WIDTH-1:0] rx_ldata_out,
    output logic [PDATA_WIDTH-1:0] rx_rdata_out,
    input  logic                   tx_valid_in,
    output logic                   tx_ready_out,
    input  logic [PDATA_WIDTH-1:0] tx_ldata_in,
    input  logic [PDATA_WIDTH-1:0] tx_rdata_in,
    output logic                   overrun_out,
    output logic                   underrun_out,
`ifdef I2S_FRAME_CTRL_STATS_EN
    output logic [STATS_WIDTH-1:0] frame_cnt_out,
    output logic [STATS_WIDTH-1:0] overrun_cnt_out,
    output logic [STATS_WIDTH-1:0] underrun_cnt_out,
`endif
    input  logic                   clear_in
);

    localparam int CNT_W = (CAPTURE_DELAY_SCLK < 2) ? 1 : $clog2(CAPTURE_DELAY_SCLK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((CAPTURE_DELAY_SCLK > 0) ? CAPTURE_DELAY_SCLK - 1 : 0);

    logic w_lrck_rise, w_lrck_fall, w_sclk_rise, w_sclk_fall;
    logic w_unused_edges;

    i2s_edge_det u_lrck_edge (
        .clk_in   (mclk_in),
        .rst_in   (rst_in),
        .level_in (lrck_in),
        .rise_out (w_lrck_rise),
        .fall_out (w_lrck_fall)
    );

    i2s_edge_det u_sclk_edge (
        .clk_in   (mclk_in),
        .rst_in   (rst_in),
        .level_in (sclk_in),
        .rise_out (w_sclk_rise),
        .fall_out (w_sclk_fall)
    );

    assign w_unused_edges = w_lrck_rise | w_sclk_fall;

    frame_state_t           r_state;
    logic [CNT_W-1:0]       r_dly_cnt;
    logic                   r_rx_valid;
    logic [PDATA_WIDTH-1:0] r_rx_ldata, r_rx_rdata;
    logic                   r_tx_empty;
    logic [PDATA_WIDTH-1:0] r_buf_ldata, r_buf_rdata;
    logic [PDATA_WIDTH-1:0] r_last_ldata, r_last_rdata;
    logic [PDATA_WIDTH-1:0] r_tx_ldata, r_tx_rdata;
    logic                   r_overrun, r_underrun;

    // Dropping enable_in in the CAPTURE state suppresses that capture entirely.
    logic w_capture, w_rx_hs, w_tx_hs, w_overrun_ev, w_underrun_ev;
    assign w_capture     = (r_state == CAPTURE) && enable_in;
    assign w_rx_hs       = r_rx_valid && rx_ready_in;
    assign w_tx_hs       = tx_valid_in && r_tx_empty;
    assign w_overrun_ev  = w_capture && r_rx_valid && !rx_ready_in;
    assign w_underrun_ev = w_capture && r_tx_empty && !tx_valid_in;

    always_ff @(posedge mclk_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_dly_cnt <= '0;
        end else if (!enable_in) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: r_state <= WAIT_EDGE;
                WAIT_EDGE: begin
                    if (w_lrck_fall) begin
                        r_dly_cnt <= '0;
                        r_state   <= (CAPTURE_DELAY_SCLK == 0) ? CAPTURE : DELAY;
                    end
                end
                DELAY: begin
                    if (w_sclk_rise) begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                        if (r_dly_cnt == CNT_LAST) begin
                            r_state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: r_state <= WAIT_EDGE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // A capture overwrites any unconsumed pair and keeps valid set even if a handshake lands here.
    always_ff @(posedge mclk_in) begin
        if (rst_in) begin
            r_rx_valid <= 1'b0;
            r_rx_ldata <= '0;
            r_rx_rdata <= '0;
        end else if (w_capture) begin
            r_rx_valid <= 1'b1;
            r_rx_ldata <= pldata_rx_in;
            r_rx_rdata <= prdata_rx_in;
        end else if (w_rx_hs) begin
            r_rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge mclk_in) begin
        if (rst_in) begin
            r_tx_empty   <= 1'b1;
            r_buf_ldata  <= '0;
            r_buf_rdata  <= '0;
            r_last_ldata <= '0;
            r_last_rdata <= '0;
            r_tx_ldata   <= '0;
            r_tx_rdata   <= '0;
        end else if (w_capture) begin
            if (!r_tx_empty) begin
                r_tx_ldata   <= r_buf_ldata;
                r_tx_rdata   <= r_buf_rdata;
                r_last_ldata <= r_buf_ldata;
                r_last_rdata <= r_buf_rdata;
                r_tx_empty   <= 1'b1;
            end else if (tx_valid_in) begin
                r_tx_ldata   <= tx_ldata_in;
                r_tx_rdata   <= tx_rdata_in;
                r_last_ldata <= tx_ldata_in;
                r_last_rdata <= tx_rdata_in;
            end else begin
                r_tx_ldata <= (UNDERRUN_HOLD != 0) ? r_last_ldata : '0;
                r_tx_rdata <= (UNDERRUN_HOLD != 0) ? r_last_rdata : '0;
            end
        end else begin
            if (!enable_in) begin
                r_tx_ldata <= '0;
                r_tx_rdata <= '0;
            end
            if (w_tx_hs) begin
                r_buf_ldata <= tx_ldata_in;
                r_buf_rdata <= tx_rdata_in;
                r_tx_empty  <= 1'b0;
            end
        end
    end

    // A fresh event outranks clear_in in the same cycle.
    always_ff @(posedge mclk_in) begin
        if (rst_in) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= w_overrun_ev | (r_overrun & ~clear_in);
            r_underrun <= w_underrun_ev | (r_underrun & ~clear_in);
        end
    end

`ifdef I2S_FRAME_CTRL_STATS_EN
    logic [STATS_WIDTH-1:0] r_frame_cnt, r_overrun_cnt, r_underrun_cnt;

    always_ff @(posedge mclk_in) begin
        if (rst_in) begin
            r_frame_cnt    <= '0;
            r_overrun_cnt  <= '0;
            r_underrun_cnt <= '0;
        end else begin
            if (w_capture)     r_frame_cnt    <= sat_inc(r_frame_cnt);
            if (w_overrun_ev)  r_overrun_cnt  <= sat_inc(r_overrun_cnt);
            if (w_underrun_ev) r_underrun_cnt <= sat_inc(r_underrun_cnt);
        end
    end

    assign frame_cnt_out    = r_frame_cnt;
    assign overrun_cnt_out  = r_overrun_cnt;
    assign underrun_cnt_out = r_underrun_cnt;
`endif

    assign pldata_tx_out = r_tx_ldata;
    assign prdata_tx_out = r_tx_rdata;
    assign rx_valid_out  = r_rx_valid;
    assign rx_ldata_out  = r_rx_ldata;
    assign rx_rdata_out  = r_rx_rdata;
    assign tx_ready_out  = r_tx_empty;
    assign overrun_out   = r_overrun;
    assign underrun_out  = r_underrun;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Bench for i2s_frame_ctrl: one zero-fill and one hold-last instance driven by a frame-level model.
// Build with I2S_FRAME_CTRL_STATS_EN to also compare the statistics counters.
module tb_i2s_frame_ctrl;

    localparam int W = 32;

    logic         mclk, rst, enable, clearIn;
    logic [7:0]   divCnt;
    logic         lrck, sclk;
    logic [W-1:0] rxLIn, rxRIn, txLIn, txRIn;
    logic         rxReady, txValid;

    logic [W-1:0] txOutL, txOutR, rxOutL, rxOutR;
    logic         rxValid, txReady, overrun, underrun;
    logic [W-1:0] holdTxL, holdTxR, holdRxL, holdRxR;
    logic         holdRxValid, holdTxReady, holdOverrun, holdUnderrun;
`ifdef I2S_FRAME_CTRL_STATS_EN
    logic [15:0]  frameCnt, overCnt, underCnt, holdFrameCnt, holdOverCnt, holdUnderCnt;
`endif

    int checks = 0;
    int errors = 0;

    bit           mPending, mBufFull, mOver, mUnder, mHoldUnder;
    logic [W-1:0] mRxL, mRxR, mBufL, mBufR, mLastL, mLastR;
    logic [W-1:0] mZeroL, mZeroR, mHoldL, mHoldR;
    int           mFrames, mOvCnt, mUnCnt, mHoldUnCnt;

    // 256 mclk per frame, 4 mclk per SCLK; LRCK changes on SCLK falling edges.
    assign lrck = divCnt[7];
    assign sclk = divCnt[1];

    i2s_frame_ctrl #(.PDATA_WIDTH(W), .CAPTURE_DELAY_SCLK(2), .UNDERRUN_HOLD(0)) dutZero (
        .mclk_in(mclk), .rst_in(rst), .enable_in(enable), .lrck_in(lrck), .sclk_in(sclk),
        .pldata_rx_in(rxLIn), .prdata_rx_in(rxRIn),
        .pldata_tx_out(txOutL), .prdata_tx_out(txOutR),
        .rx_valid_out(rxValid), .rx_ready_in(rxReady),
        .rx_ldata_out(rxOutL), .rx_rdata_out(rxOutR),
        .tx_valid_in(txValid), .tx_ready_out(txReady),
        .tx_ldata_in(txLIn), .tx_rdata_in(txRIn),
        .overrun_out(overrun), .underrun_out(underrun),
`ifdef I2S_FRAME_CTRL_STATS_EN
        .frame_cnt_out(frameCnt), .overrun_cnt_out(overCnt), .underrun_cnt_out(underCnt),
`endif
        .clear_in(clearIn)
    );

    i2s_frame_ctrl #(.PDATA_WIDTH(W), .CAPTURE_DELAY_SCLK(2), .UNDERRUN_HOLD(1)) dutHold (
        .mclk_in(mclk), .rst_in(rst), .enable_in(enable), .lrck_in(lrck), .sclk_in(sclk),
        .pldata_rx_in(rxLIn), .prdata_rx_in(rxRIn),
        .pldata_tx_out(holdTxL), .prdata_tx_out(holdTxR),
        .rx_valid_out(holdRxValid), .rx_ready_in(rxReady),
        .rx_ldata_out(holdRxL), .rx_rdata_out(holdRxR),
        .tx_valid_in(txValid), .tx_ready_out(holdTxReady),
        .tx_ldata_in(txLIn), .tx_rdata_in(txRIn),
        .overrun_out(holdOverrun), .underrun_out(holdUnderrun),
`ifdef I2S_FRAME_CTRL_STATS_EN
        .frame_cnt_out(holdFrameCnt), .overrun_cnt_out(holdOverCnt), .underrun_cnt_out(holdUnderCnt),
`endif
        .clear_in(clearIn)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        divCnt = 8'h00;
        forever begin
            @(negedge mclk);
            divCnt = divCnt + 8'h01;
        end
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to the next negedge (+1ns) at which the divider reads c.
    task automatic stepTo(input logic [7:0] c);
        int guard;
        guard = 0;
        do begin
            @(negedge mclk);
            #1;
            guard++;
        end while (divCnt != c && guard < 600);
        checkOutput("divider_reached", 32'(divCnt), 32'(c));
    endtask

    task automatic applyStimulus(input logic [W-1:0] l, input logic [W-1:0] r);
        stepTo(8'h40);
        rxLIn = l;
        rxRIn = r;
    endtask

    task automatic clearStep();
        stepTo(8'h20);
        clearIn = 1'b1;
        stepTo(8'h21);
        clearIn = 1'b0;
        mOver = 1'b0;
        mUnder = 1'b0;
        mHoldUnder = 1'b0;
        stepTo(8'h22);
        checkOutput("clear_overrun", 32'(overrun), 32'(mOver));
        checkOutput("clear_underrun", 32'(underrun), 32'(mUnder));
        checkOutput("clear_hold_underrun", 32'(holdUnderrun), 32'(mHoldUnder));
    endtask

    task automatic consumeStep();
        stepTo(8'h30);
        checkOutput("consume_valid", 32'(rxValid), 32'(mPending));
        if (mPending) begin
            checkOutput("consume_ldata", rxOutL, mRxL);
            checkOutput("consume_rdata", rxOutR, mRxR);
        end
        rxReady = 1'b1;
        stepTo(8'h31);
        rxReady = 1'b0;
        mPending = 1'b0;
        stepTo(8'h32);
        checkOutput("consume_valid_cleared", 32'(rxValid), 32'(mPending));
    endtask

    task automatic produceStep(input logic [W-1:0] l, input logic [W-1:0] r);
        stepTo(8'h50);
        checkOutput("produce_ready", 32'(txReady), 32'(!mBufFull));
        txValid = 1'b1;
        txLIn = l;
        txRIn = r;
        stepTo(8'h51);
        txValid = 1'b0;
        mBufFull = 1'b1;
        mBufL = l;
        mBufR = r;
        stepTo(8'h52);
        checkOutput("produce_ready_low", 32'(txReady), 32'(!mBufFull));
    endtask

    // Frame-level model of one capture point.
    task automatic modelCapture(input bit capReady, input bit capOffer,
                                input logic [W-1:0] offL, input logic [W-1:0] offR, input bit capClear);
        bit ov, un;
        ov = mPending && !capReady;
        un = 1'b0;
        mPending = 1'b1;
        mRxL = rxLIn;
        mRxR = rxRIn;
        if (mBufFull) begin
            mLastL = mBufL;
            mLastR = mBufR;
            mBufFull = 1'b0;
        end else if (capOffer) begin
            mLastL = offL;
            mLastR = offR;
        end else begin
            un = 1'b1;
        end
        mZeroL = un ? '0 : mLastL;
        mZeroR = un ? '0 : mLastR;
        mHoldL = mLastL;
        mHoldR = mLastR;
        mOver = ov || (mOver && !capClear);
        mUnder = un || (mUnder && !capClear);
        mHoldUnder = mUnder;
        mFrames++;
        if (ov) mOvCnt++;
        if (un) mUnCnt++;
    endtask

    task automatic captureStep(input bit capReady, input bit capOffer, input bit capClear);
        logic [W-1:0] offL, offR;
        offL = $urandom;
        offR = $urandom;
        stepTo(8'h00);
        stepTo(8'h04);
        checkOutput("pre_capture_valid", 32'(rxValid), 32'(mPending));
        stepTo(8'h07);
        rxReady = capReady;
        txValid = capOffer;
        txLIn = offL;
        txRIn = offR;
        clearIn = capClear;
        stepTo(8'h08);
        rxReady = 1'b0;
        txValid = 1'b0;
        clearIn = 1'b0;
        modelCapture(capReady, capOffer, offL, offR, capClear);
        stepTo(8'h0A);
        checkOutput("cap_rx_valid", 32'(rxValid), 32'(mPending));
        checkOutput("cap_rx_ldata", rxOutL, mRxL);
        checkOutput("cap_rx_rdata", rxOutR, mRxR);
        checkOutput("cap_overrun", 32'(overrun), 32'(mOver));
        checkOutput("cap_underrun", 32'(underrun), 32'(mUnder));
        checkOutput("cap_tx_ready", 32'(txReady), 32'(!mBufFull));
        checkOutput("cap_tx_ldata", txOutL, mZeroL);
        checkOutput("cap_tx_rdata", txOutR, mZeroR);
        checkOutput("cap_hold_tx_ldata", holdTxL, mHoldL);
        checkOutput("cap_hold_tx_rdata", holdTxR, mHoldR);
        checkOutput("cap_hold_rx_valid", 32'(holdRxValid), 32'(mPending));
        checkOutput("cap_hold_rx_ldata", holdRxL, mRxL);
        checkOutput("cap_hold_rx_rdata", holdRxR, mRxR);
        checkOutput("cap_hold_overrun", 32'(holdOverrun), 32'(mOver));
        checkOutput("cap_hold_underrun", 32'(holdUnderrun), 32'(mHoldUnder));
        checkOutput("cap_hold_tx_ready", 32'(holdTxReady), 32'(!mBufFull));
    endtask

    task automatic runFrame(input bit doClear, input bit doConsume, input bit doProduce,
                            input bit capReady, input bit capOffer, input bit capClear,
                            input logic [W-1:0] rl, input logic [W-1:0] rr,
                            input logic [W-1:0] tl, input logic [W-1:0] tr);
        if (doClear) clearStep();
        if (doConsume) consumeStep();
        applyStimulus(rl, rr);
        if (doProduce) produceStep(tl, tr);
        captureStep(capReady, capOffer, capClear);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clearIn = 1'b0;
        rxLIn = '0; rxRIn = '0; txLIn = '0; txRIn = '0;
        rxReady = 1'b0; txValid = 1'b0;
        mPending = 1'b0; mBufFull = 1'b0; mOver = 1'b0; mUnder = 1'b0; mHoldUnder = 1'b0;
        mRxL = '0; mRxR = '0; mBufL = '0; mBufR = '0; mLastL = '0; mLastR = '0;
        mZeroL = '0; mZeroR = '0; mHoldL = '0; mHoldR = '0;
        mFrames = 0; mOvCnt = 0; mUnCnt = 0; mHoldUnCnt = 0;

        stepTo(8'h10);
        checkOutput("reset_rx_valid", 32'(rxValid), 32'd0);
        checkOutput("reset_tx_ready", 32'(txReady), 32'd1);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_underrun", 32'(underrun), 32'd0);
        checkOutput("reset_tx_ldata", txOutL, '0);
        checkOutput("reset_rx_ldata", rxOutL, '0);
        checkOutput("reset_hold_tx_ready", 32'(holdTxReady), 32'd1);
        rst = 1'b0;
        enable = 1'b1;

        // First frame: known receive pair and a producer pair ahead of the capture point.
        runFrame(0, 0, 1, 0, 0, 0, 32'h12345678, 32'h9ABCDEF0, 32'hAAAA0000, 32'h5555FFFF);
        // Unconsumed second frame with no producer: overrun and underrun.
        runFrame(0, 0, 0, 0, 0, 0, $urandom, $urandom, '0, '0);
        // Flags cleared, then an event coinciding with clear_in keeps them set.
        runFrame(1, 0, 0, 0, 0, 1, $urandom, $urandom, '0, '0);
        // Bypass and consumer handshake both land in the capture cycle.
        runFrame(1, 0, 0, 1, 1, 0, $urandom, $urandom, '0, '0);

        for (int i = 0; i < 12; i++) begin
            bit doProduce;
            doProduce = 1'($urandom_range(0, 1));
            runFrame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), doProduce,
                     1'($urandom_range(0, 1)), !doProduce && 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
        end

        // Disable in the middle of the delay window, then re-enable.
        runFrame(1, 1, 1, 0, 0, 0, $urandom, $urandom, 32'hC0FFEE01, 32'h0BADF00D);
        clearStep();
        consumeStep();
        stepTo(8'h00);
        stepTo(8'h03);
        enable = 1'b0;
        stepTo(8'h04);
        mZeroL = '0; mZeroR = '0; mHoldL = '0; mHoldR = '0;
        checkOutput("disable_tx_ldata", txOutL, mZeroL);
        checkOutput("disable_tx_rdata", txOutR, mZeroR);
        checkOutput("disable_hold_tx_ldata", holdTxL, mHoldL);
        stepTo(8'h20);
        enable = 1'b1;
        stepTo(8'h30);
        checkOutput("disable_no_capture", 32'(rxValid), 32'(mPending));
        checkOutput("disable_no_underrun", 32'(underrun), 32'(mUnder));
        runFrame(0, 0, 1, 0, 0, 0, $urandom, $urandom, $urandom, $urandom);
        runFrame(0, 1, 0, 0, 0, 0, $urandom, $urandom, '0, '0);

`ifdef I2S_FRAME_CTRL_STATS_EN
        checkOutput("stats_frames", 32'(frameCnt), 32'(mFrames));
        checkOutput("stats_overruns", 32'(overCnt), 32'(mOvCnt));
        checkOutput("stats_underruns", 32'(underCnt), 32'(mUnCnt));
        checkOutput("stats_hold_frames", 32'(holdFrameCnt), 32'(mFrames));
        checkOutput("stats_hold_overruns", 32'(holdOverCnt), 32'(mOvCnt));
        checkOutput("stats_hold_underruns", 32'(holdUnderCnt), 32'(mUnCnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
